// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: arbitrates WB exceptions, interrupts and eret,
// issues the CP0 command, flushes the pipeline and redirects fetch.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000F000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          IRQ_LINES    = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wb_valid,
    input  logic [31:0]          wb_pc,
    input  logic                 wb_ri,
    input  logic                 wb_ov,
    input  logic                 wb_dz,
    input  logic                 wb_syscall,
    input  logic                 wb_break,
    input  logic                 wb_eret,
    input  logic [IRQ_LINES-1:0] ext_irq,
    input  logic [IRQ_LINES-1:0] irq_clr,
    input  logic                 status_ie,
    input  logic [IRQ_LINES-1:0] status_im,
    input  logic [31:0]          cp0_epc,
    output logic                 cp0_trap,
    output logic                 cp0_eret,
    output logic [4:0]           cp0_exc_code,
    output logic [31:0]          cp0_epc_wr,
    output logic                 flush,
    output logic                 stall,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc,
    output logic [IRQ_LINES-1:0] irq_pending
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRAP     = 3'd1,
        ST_ERET     = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_REDIRECT = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    // Returns {hit, epc_is_next, exc_code} for the highest-priority WB exception.
    function automatic logic [6:0] exc_select(input logic ri, input logic ov, input logic dz,
                                              input logic sys, input logic brk);
        logic [6:0] sel;
        if (ri)       sel = {1'b1, 1'b0, 5'd10};
        else if (ov)  sel = {1'b1, 1'b0, 5'd12};
        else if (dz)  sel = {1'b1, 1'b0, 5'd13};
        else if (sys) sel = {1'b1, 1'b1, 5'd8};
        else if (brk) sel = {1'b1, 1'b1, 5'd9};
        else          sel = 7'd0;
        return sel;
    endfunction

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [4:0]             code_q, code_d;
    logic [31:0]            epc_q, epc_d;
    logic [31:0]            target_q, target_d;
    logic [IRQ_LINES-1:0]   irq_s1_q, irq_s2_q, irq_s3_q;
    logic [IRQ_LINES-1:0]   irq_pending_q, irq_pending_d;
    logic [IRQ_LINES-1:0]   irq_rise_s;
    logic                   irq_take_s;
    logic [6:0]             exc_sel_s;
    logic [31:0]            pc_next_s;
    logic                   trap_q, eret_q, flush_q, stall_q, redirect_q;
    logic [31:0]            redirect_pc_q;

    assign exc_sel_s  = exc_select(wb_ri, wb_ov, wb_dz, wb_syscall, wb_break);
    assign pc_next_s  = wb_pc + 32'd4;
    assign irq_rise_s = irq_s2_q & ~irq_s3_q;
    assign irq_take_s = status_ie & (|(irq_pending_q & status_im));

    // Pending update: a new rising edge beats a simultaneous software clear.
    always_comb begin
        irq_pending_d = (irq_pending_q & ~irq_clr) | irq_rise_s;
    end

    // Interrupt synchronizers, edge history and pending latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_s1_q      <= '0;
            irq_s2_q      <= '0;
            irq_s3_q      <= '0;
            irq_pending_q <= '0;
        end else begin
            irq_s1_q      <= ext_irq;
            irq_s2_q      <= irq_s1_q;
            irq_s3_q      <= irq_s2_q;
            irq_pending_q <= irq_pending_d;
        end
    end

    // Next-state logic: capture happens only in IDLE with a valid WB instruction.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        epc_d    = epc_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_valid && exc_sel_s[6]) begin
                    code_d  = exc_sel_s[4:0];
                    epc_d   = exc_sel_s[5] ? pc_next_s : wb_pc;
                    state_d = ST_TRAP;
                end else if (wb_valid && irq_take_s) begin
                    code_d  = 5'd0;
                    epc_d   = pc_next_s;
                    state_d = ST_TRAP;
                end else if (wb_valid && wb_eret) begin
                    target_d = cp0_epc;
                    state_d  = ST_ERET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP: begin
                target_d = HANDLER_ADDR;
                cnt_d    = FLUSH_LAST;
                state_d  = ST_FLUSH;
            end
            ST_ERET: begin
                cnt_d   = FLUSH_LAST;
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and captured trap/redirect context.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            code_q   <= 5'd0;
            epc_q    <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end

    // Output registers decoded from the next state so they align with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap_q        <= 1'b0;
            eret_q        <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            trap_q        <= (state_d == ST_TRAP);
            eret_q        <= (state_d == ST_ERET);
            flush_q       <= (state_d == ST_FLUSH);
            stall_q       <= (state_d != ST_IDLE);
            redirect_q    <= (state_d == ST_REDIRECT);
            redirect_pc_q <= (state_d == ST_REDIRECT) ? target_d : 32'd0;
        end
    end

    assign cp0_trap     = trap_q;
    assign cp0_eret     = eret_q;
    assign cp0_exc_code = code_q;
    assign cp0_epc_wr   = epc_q;
    assign flush        = flush_q;
    assign stall        = stall_q;
    assign pc_redirect  = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign irq_pending  = irq_pending_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios followed by random
// stimulus, all checked every cycle against a transaction-level reference model.
module tb_exc_sequencer;

    localparam logic [31:0] HANDLER = 32'h0000F000;
    localparam int          NFLUSH  = 2;

    logic        clock, reset;
    logic        wb_valid, wb_ri, wb_ov, wb_dz, wb_syscall, wb_break, wb_eret;
    logic [31:0] wb_pc, cp0_epc;
    logic [5:0]  ext_irq, irq_clr, status_im;
    logic        status_ie;
    logic        cp0_trap, cp0_eret, flush, stall, pc_redirect;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_epc_wr, redirect_pc;
    logic [5:0]  irq_pending;

    exc_sequencer #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(NFLUSH), .IRQ_LINES(6)) dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_ri(wb_ri), .wb_ov(wb_ov), .wb_dz(wb_dz), .wb_syscall(wb_syscall),
        .wb_break(wb_break), .wb_eret(wb_eret), .ext_irq(ext_irq), .irq_clr(irq_clr),
        .status_ie(status_ie), .status_im(status_im), .cp0_epc(cp0_epc),
        .cp0_trap(cp0_trap), .cp0_eret(cp0_eret), .cp0_exc_code(cp0_exc_code),
        .cp0_epc_wr(cp0_epc_wr), .flush(flush), .stall(stall), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected per-cycle output of one sequence step.
    typedef struct packed {
        logic        trap;
        logic        eret;
        logic        flush;
        logic        redir;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] rpc;
    } exp_t;

    exp_t       seq_q[$];
    exp_t       cur_m;
    bit         busy_m;
    logic [5:0] pend_m;
    logic [5:0] samp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        seq_q.delete();
        samp_q.delete();
        repeat (4) samp_q.push_back(6'd0);
        cur_m  = '0;
        busy_m = 0;
        pend_m = 6'd0;
    endtask

    task automatic push_seq(input bit is_trap, input logic [4:0] code,
                            input logic [31:0] epc, input logic [31:0] target);
        exp_t e;
        e = '0;
        e.trap = is_trap;
        e.eret = !is_trap;
        e.code = code;
        e.epc  = epc;
        seq_q.push_back(e);
        e = '0;
        e.flush = 1'b1;
        repeat (NFLUSH) seq_q.push_back(e);
        e = '0;
        e.redir = 1'b1;
        e.rpc   = target;
        seq_q.push_back(e);
    endtask

    // Model of one rising edge, using the inputs that are stable across it.
    task automatic model_edge();
        logic [5:0] rise;
        if (!busy_m && wb_valid) begin
            if (wb_ri)            push_seq(1, 5'd10, wb_pc, HANDLER);
            else if (wb_ov)       push_seq(1, 5'd12, wb_pc, HANDLER);
            else if (wb_dz)       push_seq(1, 5'd13, wb_pc, HANDLER);
            else if (wb_syscall)  push_seq(1, 5'd8, wb_pc + 32'd4, HANDLER);
            else if (wb_break)    push_seq(1, 5'd9, wb_pc + 32'd4, HANDLER);
            else if (status_ie && (pend_m & status_im) != 6'd0)
                                  push_seq(1, 5'd0, wb_pc + 32'd4, HANDLER);
            else if (wb_eret)     push_seq(0, 5'd0, 32'd0, cp0_epc);
        end
        if (seq_q.size() > 0) begin
            cur_m  = seq_q.pop_front();
            busy_m = 1;
        end else begin
            cur_m  = '0;
            busy_m = 0;
        end
        // An ext_irq rise sampled two edges ago becomes pending now.
        samp_q.push_back(ext_irq);
        rise   = samp_q[samp_q.size()-3] & ~samp_q[samp_q.size()-4];
        pend_m = (pend_m & ~irq_clr) | rise;
        if (samp_q.size() > 8) void'(samp_q.pop_front());
    endtask

    task automatic compare();
        check_eq("cp0_trap", cp0_trap, cur_m.trap);
        check_eq("cp0_eret", cp0_eret, cur_m.eret);
        check_eq("flush", flush, cur_m.flush);
        check_eq("stall", stall, busy_m);
        check_eq("pc_redirect", pc_redirect, cur_m.redir);
        check_eq("redirect_pc", redirect_pc, cur_m.rpc);
        check_eq("irq_pending", irq_pending, pend_m);
        if (cur_m.trap) begin
            check_eq("exc_code", cp0_exc_code, cur_m.code);
            check_eq("epc_wr", cp0_epc_wr, cur_m.epc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_ri = 0; wb_ov = 0; wb_dz = 0;
        wb_syscall = 0; wb_break = 0; wb_eret = 0; irq_clr = 6'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] one6;
        one6 = 6'b000001;
        reset = 1'b1;
        clear_wb();
        wb_pc = 32'd0; cp0_epc = 32'd0; ext_irq = 6'd0;
        status_ie = 1'b0; status_im = 6'd0;
        model_reset();
        #3;
        compare();
        @(negedge clock);
        reset = 1'b0;
        step();

        // Overflow trap
        wb_valid = 1; wb_ov = 1; wb_pc = 32'h00000040;
        step();
        clear_wb();
        check_eq("ov_code", cp0_exc_code, 32'd12);
        check_eq("ov_epc", cp0_epc_wr, 32'h40);
        repeat (NFLUSH) step();
        step();
        check_eq("ov_redirect", redirect_pc, HANDLER);
        step();

        // Reserved instruction beats syscall
        wb_valid = 1; wb_ri = 1; wb_syscall = 1; wb_pc = 32'h100;
        step();
        clear_wb();
        check_eq("ri_code", cp0_exc_code, 32'd10);
        check_eq("ri_epc", cp0_epc_wr, 32'h100);
        repeat (NFLUSH + 2) step();

        // Eret target sampled at decision time
        wb_valid = 1; wb_eret = 1; cp0_epc = 32'h1234;
        step();
        clear_wb();
        check_eq("eret_pulse", cp0_eret, 1'b1);
        cp0_epc = 32'hDEADBEEC;
        repeat (NFLUSH) step();
        step();
        check_eq("eret_target", redirect_pc, 32'h1234);
        step();

        // Interrupt: latency, masked, then taken
        status_ie = 1; status_im = 6'b000100; ext_irq[2] = 1'b1;
        step(); step();
        check_eq("irq_lat2", irq_pending[2], 1'b0);
        step();
        check_eq("irq_lat3", irq_pending[2], 1'b1);
        status_im = 6'd0; wb_valid = 1; wb_pc = 32'h200;
        step();
        check_eq("irq_masked", cp0_trap, 1'b0);
        status_im = 6'b000100;
        step();
        clear_wb();
        status_ie = 0;
        check_eq("irq_code", cp0_exc_code, 32'd0);
        check_eq("irq_epc", cp0_epc_wr, 32'h204);
        repeat (NFLUSH + 2) step();
        check_eq("irq_persist", irq_pending[2], 1'b1);

        // Same-cycle set and clear on bit 3
        ext_irq[3] = 1'b1;
        step(); step();
        irq_clr = 6'b001000;
        step();
        irq_clr = 6'd0;
        check_eq("set_beats_clr", irq_pending[3], 1'b1);

        // Break at top of memory, dz during flush, reset mid-flush
        wb_valid = 1; wb_break = 1; wb_pc = 32'hFFFFFFFC;
        step();
        clear_wb();
        check_eq("brk_epc_wrap", cp0_epc_wr, 32'd0);
        wb_valid = 1; wb_dz = 1;
        step();
        check_eq("in_flush", flush, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("rst_flush", flush, 1'b0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_pending", irq_pending, 32'd0);
        clear_wb();
        ext_irq = 6'd0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (4) step();

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_ri      = ($urandom_range(0, 15) == 0);
            wb_ov      = ($urandom_range(0, 15) == 0);
            wb_dz      = ($urandom_range(0, 15) == 0);
            wb_syscall = ($urandom_range(0, 15) == 0);
            wb_break   = ($urandom_range(0, 15) == 0);
            wb_eret    = ($urandom_range(0, 7) == 0);
            wb_pc      = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            cp0_epc    = $urandom();
            if ($urandom_range(0, 7) == 0) ext_irq = ext_irq ^ (one6 << $urandom_range(0, 5));
            irq_clr    = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : 6'd0;
            status_ie  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) status_im = 6'($urandom());
            if (i == 1500) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Exception/interrupt sequencer for the Minisys-1A pipeline.
- Collects exception flags and the PC of the write-back (WB) instruction, plus external interrupt lines.
- Arbitrates between these sources by fixed priority and drives the coprocessor-0 register file with a one-cycle trap or eret command.
- Then flushes the pipeline for a fixed number of cycles and redirects fetch to the handler entry or to EPC.

Parameters:
- HANDLER_ADDR, 32'h0000F000, single entry address for all exceptions and interrupts.
- FLUSH_CYCLES, 2, number of cycles flush is held high (legal range 1..15).
- IRQ_LINES, 6, number of external interrupt lines.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  WB stage holds a real (non-bubble) instruction this cycle.
- wb_pc  in  32  PC of the WB instruction.
- wb_ri  in  1  reserved-instruction flag.
- wb_ov  in  1  arithmetic-overflow flag.
- wb_dz  in  1  divide-by-zero flag.
- wb_syscall  in  1  syscall flag.
- wb_break  in  1  break flag.
- wb_eret  in  1  eret flag.
- ext_irq  in  IRQ_LINES  asynchronous level interrupt lines.
- irq_clr  in  IRQ_LINES  one-cycle software clear pulses, one per pending bit.
- status_ie  in  1  CP0 Status global interrupt enable.
- status_im  in  IRQ_LINES  CP0 Status interrupt mask; 1 = enabled.
- cp0_epc  in  32  current CP0 EPC value.
- cp0_trap  out  1  one-cycle command to CP0: save IE/KSU, write Cause.ExcCode and EPC.
- cp0_eret  out  1  one-cycle command to CP0: restore IE/KSU.
- cp0_exc_code  out  5  ExcCode accompanying cp0_trap.
- cp0_epc_wr  out  32  EPC value accompanying cp0_trap.
- flush  out  1  kill all IF..WB instructions.
- stall  out  1  freeze the WB stage; high in every non-IDLE state.
- pc_redirect  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  redirect target; valid while pc_redirect is high.
- irq_pending  out  IRQ_LINES  latched pending interrupts, readable by software.

Behaviour:
- Reset (async): state IDLE; flush counter 0; synchronizers and irq_pending cleared; every output 0.

Interrupt input path:
- Each ext_irq bit passes through a 2-flop synchronizer.
- A rising edge of the synchronized bit sets the matching irq_pending bit.
- An irq_clr pulse clears the bit. If set and clear occur in the same cycle, set wins.
- Edge-to-pending latency is 3 clocks.
- irq_take = status_ie & |(irq_pending & status_im).

Arbitration (IDLE only, and only when wb_valid=1), highest priority first:
- wb_ri: code 10, EPC = wb_pc.
- wb_ov: code 12, EPC = wb_pc.
- wb_dz: code 13, EPC = wb_pc.
- wb_syscall: code 8, EPC = wb_pc+4.
- wb_break: code 9, EPC = wb_pc+4.
- irq_take: code 0, EPC = wb_pc+4. The WB instruction retires.
- wb_eret: eret path.
- Any exception flag masks wb_eret and interrupts.
- wb_pc+4 is modulo 2^32, so 32'hFFFFFFFC + 4 = 0.

FSM states:
- IDLE: stall=0.
  - On an exception or interrupt: register code and EPC, go to TRAP.
  - On eret: latch cp0_epc as target, go to ERET.
  - Otherwise stay in IDLE.
- TRAP: cp0_trap=1 for exactly 1 cycle, with cp0_exc_code/cp0_epc_wr stable. Target = HANDLER_ADDR. Go to FLUSH.
- ERET: cp0_eret=1 for exactly 1 cycle. Go to FLUSH.
- FLUSH: flush=1 for exactly FLUSH_CYCLES consecutive cycles, counted down from FLUSH_CYCLES-1 to 0. Go to REDIRECT.
- REDIRECT: pc_redirect=1 with redirect_pc = target for 1 cycle. Go to IDLE.
- Total sequence length is FLUSH_CYCLES+2 cycles.

Rules:
- Flags, wb_valid and irq_take are ignored outside IDLE; the pipeline is being flushed, so no nested capture occurs.
- Pending interrupts persist and may be taken on the first IDLE cycle after REDIRECT.
- The eret target is sampled from cp0_epc in the IDLE cycle that decides eret. Later CP0 changes do not affect it.
- cp0_trap and cp0_eret are never high in the same cycle.
- flush and pc_redirect never overlap.
- Reset asserted mid-sequence aborts immediately to IDLE with all outputs 0; no partial redirect is issued.

Test Plan:
- wb_valid=1, wb_ov=1, wb_pc=32'h00000040 → next cycle cp0_trap=1 with code 12 and EPC 32'h40; flush high for 2 cycles; then pc_redirect=1 with redirect_pc=32'h0000F000.
- wb_ri=1 and wb_syscall=1 together, wb_pc=32'h100 → code 10, EPC 32'h100; syscall ignored.
- ext_irq[2] rises with status_ie=1, status_im=6'b000100 → irq_pending[2]=1 after 3 clocks. With wb_valid=1 and wb_pc=32'h200: trap code 0, EPC 32'h204. With status_im[2]=0 instead: no trap, and irq_pending[2] stays 1.
- wb_eret=1 with cp0_epc=32'h1234 → cp0_eret pulse; flush ×2; pc_redirect with redirect_pc=32'h1234. Changing cp0_epc during FLUSH leaves the target unchanged.
- wb_break=1 at wb_pc=32'hFFFFFFFC → EPC 0. Asserting wb_dz during FLUSH produces no second trap.
- Assert reset during FLUSH → all outputs 0 immediately, state IDLE, irq_pending cleared. irq_clr and a rising-edge set on the same bit in the same cycle → bit remains 1.
